bpu_btb_predictor: RTL and testbench
====================================

// Module: bpu_btb_predictor
// PURPOSE
//  Parametrised dynamic branch predictor (direct-mapped BTB + saturating-counter BHT) for the next-gen 5-stage core.
//  IF queries it combinationally with the current word PC; on a predicted-taken hit, PC loads the predicted target next cycle.
//  EX reports resolved branch/jump outcomes, which train the table one cycle later.
//  Replaces flush-on-every-taken-branch; PRED_MODE=0 degrades to static not-taken for A/B benchmarking.
// PARAMETERS
//  ADDR_BIT   10  word-address width of PC and targets (matches IM address width)
//  IDX_BIT    4   log2 table entries (16); index = pc[IDX_BIT-1:0], tag = pc[ADDR_BIT-1:IDX_BIT]
//  CTR_BIT    2   saturating counter width, >=1
//  PRED_MODE  1   0 = static not-taken (never predicts, no training), 1 = dynamic
//  PERF_BIT   32  width of performance counters
// PORTS
//  clk             in   1         core clock, all state on rising edge
//  rst             in   1         synchronous reset, active-high
//  en              in   1         global enable; 0 freezes all state (lookup stays live)
//  lk_pc           in   ADDR_BIT  IF-stage word PC
//  lk_taken        out  1         prediction: redirect to lk_target
//  lk_target       out  ADDR_BIT  predicted target (0 when lk_taken=0)
//  upd_valid       in   1         EX has a resolved control-flow instr this cycle
//  upd_pc          in   ADDR_BIT  word PC of that instr
//  upd_is_jump     in   1         1 = unconditional (j/jal/jr), 0 = conditional branch
//  upd_taken       in   1         actual outcome
//  upd_target      in   ADDR_BIT  actual target
//  upd_mispredict  in   1         EX detected wrong prediction (counted only)
//  perf_lookups    out  PERF_BIT  upd_valid events counted
//  perf_mispred    out  PERF_BIT  upd_mispredict events counted
// BEHAVIOUR
//  - Lookup fully combinational, zero latency: hit = valid[idx] & tag[idx]==lk_tag;
//    lk_taken = PRED_MODE & hit & (jmp[idx] | ctr[idx][CTR_BIT-1]); lk_target = lk_taken ? tgt[idx] : 0.
//  - Update registered: when en & upd_valid & PRED_MODE, entry upd_pc[IDX_BIT-1:0] changes at next edge.
//    * hit, branch: taken -> ctr+1 saturating at 2^CTR_BIT-1; not taken -> ctr-1 saturating at 0; tgt <= upd_target if taken.
//    * hit, jump: tgt <= upd_target, ctr <= max, jmp <= 1.
//    * miss & upd_taken: allocate (overwrite): valid=1, tag, tgt, jmp=upd_is_jump, ctr = jump ? max : 2^(CTR_BIT-1) (weakly taken).
//    * miss & !upd_taken: no change (no allocation of not-taken branches).
//  - Simultaneous lookup and update of same index: lookup sees pre-update contents (no bypass).
//  - CTR_BIT=1: weakly taken == max == 1; saturation rules still hold.
//  - Perf counters: +1 per en&upd_valid / en&upd_mispredict; saturate at all-ones, never wrap; count in both modes.
//  - rst (dominates en): all valid=0, jmp=0, ctr=2^(CTR_BIT-1)-1 (weakly not taken, 0 when CTR_BIT=1), tgt/tag=0, perf=0;
//    outputs after reset: lk_taken=0, lk_target=0. Reset mid-training discards the table in one cycle.
//  - en=0: no table or perf update even if upd_valid=1; outputs still track lk_pc.
//  - Table held in flops (not RAM) so reset clears in one cycle and lookup is asynchronous.
// STRUCTURE
//  - Core.vh gains: BPU_ADDR_BIT, BPU_IDX_BIT, BPU_CTR_BIT defaults and PRED_MODE_STATIC/PRED_MODE_DYN constants.
//  - Sub-module bpu_sat_ctr (CTR_BIT wide up/down saturating counter with load), one per entry via generate.
//  - Perf counters inline; no FSM beyond per-entry counters.
// TESTING
//  1 Reset: rst=1 one cycle, any lk_pc -> lk_taken=0, lk_target=0, perf_*=0.
//  2 Allocate: upd pc=0x024 branch taken tgt=0x010 -> next cycle lk_pc=0x024 gives taken, target 0x010; lk_pc=0x034 (same idx, other tag) -> 0.
//  3 Saturation: 3 more taken then 2 not-taken on 0x024 -> still taken (ctr 3->1? no: 3,2) after 1st NT, not taken after 2nd NT (ctr=1); 5 NT -> ctr stays 0.
//  4 Jump: upd jump pc=0x008 tgt=0x100, then NT reports -> lk stays taken to 0x100; miss & NT at 0x00C -> no allocation.
//  5 Same-index collision + en: lookup and update 0x024 same cycle -> old value returned; en=0 with upd_valid -> table and perf unchanged.
//  6 PRED_MODE=0 and perf saturation (PERF_BIT=4): 20 updates -> lk_taken always 0, perf_lookups=15.

Source files
------------

// File: rtl/bpu_btb_predictor_pkg.sv
// Shared defaults and mode constants for the branch predictor block.
// Top-level parameters take their default values from here.
package bpu_btb_predictor_pkg;
    localparam int BPU_ADDR_BIT     = 10;
    localparam int BPU_IDX_BIT      = 4;
    localparam int BPU_CTR_BIT      = 2;
    localparam int BPU_PERF_BIT     = 32;
    localparam int PRED_MODE_STATIC = 0;
    localparam int PRED_MODE_DYN    = 1;
endpackage

// File: rtl/bpu_btb_predictor_sat_ctr.sv
// Up/down saturating counter with parallel load; one instance per BTB entry.
// Resets to weakly-not-taken (0 for a 1-bit counter).
module bpu_sat_ctr
    import bpu_btb_predictor_pkg::*;
#(
    parameter int CTR_BIT = BPU_CTR_BIT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               step,
    input  logic               up,
    input  logic               load,
    input  logic [CTR_BIT-1:0] load_val,
    output logic [CTR_BIT-1:0] ctr
);
    localparam logic [CTR_BIT-1:0] CTR_MAX = '1;
    localparam logic [CTR_BIT-1:0] CTR_RST = CTR_MAX >> 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            ctr <= CTR_RST;
        end else if (load) begin
            ctr <= load_val;
        end else if (step) begin
            if (up && ctr != CTR_MAX)
                ctr <= ctr + CTR_BIT'(1);
            else if (!up && ctr != '0)
                ctr <= ctr - CTR_BIT'(1);
        end
    end
endmodule

// File: rtl/bpu_btb_predictor.sv
// Direct-mapped BTB with per-entry saturating counters; combinational lookup,
// update committed on the edge after EX reports an outcome.
module bpu_btb_predictor
    import bpu_btb_predictor_pkg::*;
#(
    parameter int ADDR_BIT  = BPU_ADDR_BIT,
    parameter int IDX_BIT   = BPU_IDX_BIT,
    parameter int CTR_BIT   = BPU_CTR_BIT,
    parameter int PRED_MODE = PRED_MODE_DYN,
    parameter int PERF_BIT  = BPU_PERF_BIT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [ADDR_BIT-1:0] lk_pc,
    output logic                lk_taken,
    output logic [ADDR_BIT-1:0] lk_target,
    input  logic                upd_valid,
    input  logic [ADDR_BIT-1:0] upd_pc,
    input  logic                upd_is_jump,
    input  logic                upd_taken,
    input  logic [ADDR_BIT-1:0] upd_target,
    input  logic                upd_mispredict,
    output logic [PERF_BIT-1:0] perf_lookups,
    output logic [PERF_BIT-1:0] perf_mispred
);
    localparam int ENTRIES = 1 << IDX_BIT;
    localparam int TAG_BIT = ADDR_BIT - IDX_BIT;
    localparam logic [CTR_BIT-1:0] CTR_MAX = '1;
    localparam logic [CTR_BIT-1:0] CTR_WT  = ~(CTR_MAX >> 1);

    logic [ENTRIES-1:0]               valid;
    logic [ENTRIES-1:0]               jmp;
    logic [ENTRIES-1:0][TAG_BIT-1:0]  tag;
    logic [ENTRIES-1:0][ADDR_BIT-1:0] tgt;
    logic [ENTRIES-1:0][CTR_BIT-1:0]  ctr;

    logic [IDX_BIT-1:0] lk_idx, upd_idx;
    logic [TAG_BIT-1:0] lk_tag, upd_tag;
    logic               lk_hit, upd_hit, do_upd;
    logic [CTR_BIT-1:0] alloc_ctr;

    assign lk_idx  = lk_pc[IDX_BIT-1:0];
    assign lk_tag  = lk_pc[ADDR_BIT-1:IDX_BIT];
    assign upd_idx = upd_pc[IDX_BIT-1:0];
    assign upd_tag = upd_pc[ADDR_BIT-1:IDX_BIT];

    // Lookup reads the pre-update table; no bypass from a same-cycle update.
    assign lk_hit    = valid[lk_idx] && (tag[lk_idx] == lk_tag);
    assign lk_taken  = (PRED_MODE != 0) && lk_hit && (jmp[lk_idx] || ctr[lk_idx][CTR_BIT-1]);
    assign lk_target = lk_taken ? tgt[lk_idx] : '0;

    assign do_upd    = en && upd_valid && (PRED_MODE != 0);
    assign upd_hit   = valid[upd_idx] && (tag[upd_idx] == upd_tag);
    assign alloc_ctr = upd_is_jump ? CTR_MAX : CTR_WT;

    for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
        logic                sel, ctr_step, ctr_load;
        logic                e_valid, e_jmp;
        logic [TAG_BIT-1:0]  e_tag;
        logic [ADDR_BIT-1:0] e_tgt;

        assign sel = do_upd && (upd_idx == IDX_BIT'(i));
        // Counter is loaded on jump hits and on allocation; stepped on branch hits.
        assign ctr_load = sel && (upd_hit ? upd_is_jump : upd_taken);
        assign ctr_step = sel && upd_hit && !upd_is_jump;

        bpu_sat_ctr #(.CTR_BIT(CTR_BIT)) u_ctr (
            .clk      (clk),
            .rst      (rst),
            .step     (ctr_step),
            .up       (upd_taken),
            .load     (ctr_load),
            .load_val (alloc_ctr),
            .ctr      (ctr[i])
        );

        always_ff @(posedge clk) begin
            if (rst) begin
                e_valid <= 1'b0;
                e_jmp   <= 1'b0;
                e_tag   <= '0;
                e_tgt   <= '0;
            end else if (sel) begin
                if (upd_hit) begin
                    if (upd_is_jump || upd_taken)
                        e_tgt <= upd_target;
                    if (upd_is_jump)
                        e_jmp <= 1'b1;
                end else if (upd_taken) begin
                    e_valid <= 1'b1;
                    e_jmp   <= upd_is_jump;
                    e_tag   <= upd_tag;
                    e_tgt   <= upd_target;
                end
            end
        end

        assign valid[i] = e_valid;
        assign jmp[i]   = e_jmp;
        assign tag[i]   = e_tag;
        assign tgt[i]   = e_tgt;
    end

    // Perf counters saturate at all-ones and count in both modes.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_lookups <= '0;
            perf_mispred <= '0;
        end else if (en) begin
            if (upd_valid && !(&perf_lookups))
                perf_lookups <= perf_lookups + PERF_BIT'(1);
            if (upd_mispredict && !(&perf_mispred))
                perf_mispred <= perf_mispred + PERF_BIT'(1);
        end
    end
endmodule

// File: tb/tb_bpu_btb_predictor.sv
// Directed bench: vector table for the dynamic predictor plus hand sequences
// for reset-during-training and static mode with narrow perf counters.
module tb_bpu_btb_predictor;
    logic       clk = 1'b0;
    logic       rst, en, en2;
    logic [9:0] lk_pc, upd_pc, upd_target;
    logic       upd_valid, upd_valid2, upd_is_jump, upd_taken, upd_mispredict, upd_mispredict2;
    logic       lk_taken, lk_taken2;
    logic [9:0] lk_target, lk_target2;
    logic [31:0] perf_lookups, perf_mispred;
    logic [3:0]  perf_lookups2, perf_mispred2;

    always #5 clk = ~clk;

    bpu_btb_predictor #(.ADDR_BIT(10), .IDX_BIT(4), .CTR_BIT(2), .PRED_MODE(1), .PERF_BIT(32)) dut (
        .clk(clk), .rst(rst), .en(en), .lk_pc(lk_pc), .lk_taken(lk_taken), .lk_target(lk_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .perf_lookups(perf_lookups), .perf_mispred(perf_mispred)
    );

    bpu_btb_predictor #(.ADDR_BIT(10), .IDX_BIT(4), .CTR_BIT(2), .PRED_MODE(0), .PERF_BIT(4)) dut_static (
        .clk(clk), .rst(rst), .en(en2), .lk_pc(lk_pc), .lk_taken(lk_taken2), .lk_target(lk_target2),
        .upd_valid(upd_valid2), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispredict(upd_mispredict2),
        .perf_lookups(perf_lookups2), .perf_mispred(perf_mispred2)
    );

    typedef struct {
        logic       en, uv;
        logic [9:0] pc;
        logic       j, t;
        logic [9:0] tgt;
        logic       mp;
        logic [9:0] lk;
        logic       exp_taken;
        logic [9:0] exp_target;
    } vec_t;

    vec_t vq[$];
    int n_pass = 0, n_total = 0;
    int exp_lk = 0, exp_mp = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic add(input logic e, input logic uv, input logic [9:0] pc, input logic j,
                       input logic t, input logic [9:0] tgt, input logic mp, input logic [9:0] lk,
                       input logic et, input logic [9:0] etgt);
        vec_t v;
        v.en = e; v.uv = uv; v.pc = pc; v.j = j; v.t = t; v.tgt = tgt; v.mp = mp;
        v.lk = lk; v.exp_taken = et; v.exp_target = etgt;
        vq.push_back(v);
    endtask

    initial begin
        // reset / allocate / collision probe
        add(1, 0, 10'h000, 0, 0, 10'h000, 0, 10'h024, 0, 10'h000);
        add(1, 1, 10'h024, 0, 1, 10'h010, 0, 10'h024, 0, 10'h000);
        add(1, 0, 10'h000, 0, 0, 10'h000, 0, 10'h024, 1, 10'h010);
        add(1, 0, 10'h000, 0, 0, 10'h000, 0, 10'h034, 0, 10'h000);
        // saturate up, then walk down
        for (int i = 0; i < 3; i++) add(1, 1, 10'h024, 0, 1, 10'h010, 0, 10'h024, 1, 10'h010);
        add(1, 1, 10'h024, 0, 0, 10'h000, 1, 10'h024, 1, 10'h010);
        add(1, 1, 10'h024, 0, 0, 10'h000, 0, 10'h024, 1, 10'h010);
        add(1, 0, 10'h000, 0, 0, 10'h000, 0, 10'h024, 0, 10'h000);
        for (int i = 0; i < 5; i++) add(1, 1, 10'h024, 0, 0, 10'h000, 0, 10'h024, 0, 10'h000);
        // one taken from floor must give 1 (still not taken), not a wrap
        add(1, 1, 10'h024, 0, 1, 10'h010, 1, 10'h024, 0, 10'h000);
        add(1, 0, 10'h000, 0, 0, 10'h000, 0, 10'h024, 0, 10'h000);
        add(1, 1, 10'h024, 0, 1, 10'h020, 0, 10'h024, 0, 10'h000);
        add(1, 0, 10'h000, 0, 0, 10'h000, 0, 10'h024, 1, 10'h020);
        // jump entry ignores not-taken reports
        add(1, 1, 10'h008, 1, 1, 10'h100, 0, 10'h008, 0, 10'h000);
        add(1, 1, 10'h008, 0, 0, 10'h000, 0, 10'h008, 1, 10'h100);
        add(1, 1, 10'h008, 0, 0, 10'h000, 0, 10'h008, 1, 10'h100);
        add(1, 0, 10'h000, 0, 0, 10'h000, 0, 10'h008, 1, 10'h100);
        // not-taken miss never allocates
        add(1, 1, 10'h00C, 0, 0, 10'h040, 0, 10'h00C, 0, 10'h000);
        add(1, 0, 10'h000, 0, 0, 10'h000, 0, 10'h00C, 0, 10'h000);
        // same-index overwrite, same-cycle lookup sees old entry
        add(1, 1, 10'h034, 0, 1, 10'h3FF, 0, 10'h024, 1, 10'h020);
        add(1, 0, 10'h000, 0, 0, 10'h000, 0, 10'h024, 0, 10'h000);
        add(1, 0, 10'h000, 0, 0, 10'h000, 0, 10'h034, 1, 10'h3FF);
        // en=0 freezes table and perf
        add(0, 1, 10'h034, 0, 0, 10'h000, 1, 10'h034, 1, 10'h3FF);
        add(0, 1, 10'h034, 0, 0, 10'h000, 1, 10'h034, 1, 10'h3FF);
        add(1, 0, 10'h000, 0, 0, 10'h000, 0, 10'h034, 1, 10'h3FF);

        rst = 1'b1; en = 1'b1; en2 = 1'b1; lk_pc = 10'h024;
        upd_valid = 1'b0; upd_valid2 = 1'b0; upd_pc = '0; upd_is_jump = 1'b0;
        upd_taken = 1'b0; upd_target = '0; upd_mispredict = 1'b0; upd_mispredict2 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        for (int r = 0; r < vq.size(); r++) begin
            en = vq[r].en; upd_valid = vq[r].uv; upd_pc = vq[r].pc; upd_is_jump = vq[r].j;
            upd_taken = vq[r].t; upd_target = vq[r].tgt; upd_mispredict = vq[r].mp; lk_pc = vq[r].lk;
            #3;
            check($sformatf("row%0d lk_taken", r), 32'(lk_taken), 32'(vq[r].exp_taken));
            check($sformatf("row%0d lk_target", r), 32'(lk_target), 32'(vq[r].exp_target));
            check($sformatf("row%0d perf_lookups", r), perf_lookups, 32'(exp_lk));
            check($sformatf("row%0d perf_mispred", r), perf_mispred, 32'(exp_mp));
            if (vq[r].en && vq[r].uv) exp_lk++;
            if (vq[r].en && vq[r].mp) exp_mp++;
            @(posedge clk); #1;
        end
        en = 1'b1; upd_valid = 1'b0; upd_mispredict = 1'b0;
        #3;
        check("static perf idle", 32'(perf_lookups2), 32'd0);

        // reset with a concurrent update: rst wins, table wiped in one cycle
        @(posedge clk); #1;
        rst = 1'b1; upd_valid = 1'b1; upd_pc = 10'h024; upd_is_jump = 1'b0;
        upd_taken = 1'b1; upd_target = 10'h055; upd_mispredict = 1'b1; lk_pc = 10'h034;
        @(posedge clk); #1;
        rst = 1'b0; upd_valid = 1'b0; upd_mispredict = 1'b0;
        #3;
        check("rst lk_taken 034", 32'(lk_taken), 32'd0);
        check("rst lk_target 034", 32'(lk_target), 32'd0);
        check("rst perf_lookups", perf_lookups, 32'd0);
        check("rst perf_mispred", perf_mispred, 32'd0);
        lk_pc = 10'h024;
        #1;
        check("rst lk_taken 024", 32'(lk_taken), 32'd0);

        // static mode: never predicts, perf saturates at 15
        @(posedge clk); #1;
        for (int k = 0; k < 20; k++) begin
            upd_valid2 = 1'b1; upd_mispredict2 = 1'b1; upd_pc = 10'h008; upd_is_jump = 1'b1;
            upd_taken = 1'b1; upd_target = 10'h100; lk_pc = 10'h008;
            #3;
            if (k % 5 == 4) check($sformatf("static lk_taken k%0d", k), 32'(lk_taken2), 32'd0);
            @(posedge clk); #1;
        end
        upd_valid2 = 1'b0; upd_mispredict2 = 1'b0;
        #3;
        check("static lk_taken final", 32'(lk_taken2), 32'd0);
        check("static lk_target final", 32'(lk_target2), 32'd0);
        check("static perf_lookups sat", 32'(perf_lookups2), 32'd15);
        check("static perf_mispred sat", 32'(perf_mispred2), 32'd15);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
